// File: rtl/irq_priority_scheduler_if.sv
// Grant handshake between the interrupt scheduler and the injection sequencer.
interface irq_priority_scheduler_if #(
    parameter int ID_W = 3
);
    logic            grant_valid;
    logic [ID_W-1:0] grant_id;
    logic            grant_ready;

    modport master (output grant_valid, output grant_id, input grant_ready);
    modport slave  (input grant_valid, input grant_id, output grant_ready);
endinterface

// File: rtl/irq_priority_scheduler.sv
// Interrupt front-end: edge capture, masking, nested priority resolution and a valid/ready grant offer.
// Optional build macro IRQ_ROTATE_PRIORITY_EN enables rotating priority via a pointer register.
module irq_priority_scheduler #(
    parameter int NUM_SRC  = 8,
    parameter int ID_W     = 3,
    parameter int MAX_NEST = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_SRC-1:0]     irq,
    input  logic [NUM_SRC-1:0]     imr,
    input  logic                   eoi,
    output logic [NUM_SRC-1:0]     pending,
    output logic [NUM_SRC-1:0]     in_service,
    output logic                   eoi_err,
    irq_priority_scheduler_if.master gnt
);

    typedef enum logic {IDLE, OFFER} state_t;

    state_t              state;
    logic [NUM_SRC-1:0]  irq_q;
    logic                offer_vld;
    logic [ID_W-1:0]     offer_id;
`ifdef IRQ_ROTATE_PRIORITY_EN
    logic [ID_W-1:0]     ptr;
`endif

    logic [NUM_SRC-1:0]  rise;
    logic [NUM_SRC-1:0]  thr_mask;
    logic [NUM_SRC-1:0]  eoi_clear;
    logic [NUM_SRC-1:0]  acc_mask;
    logic                acc;
    logic                nest_full;
    logic                any_elig;
    logic [ID_W-1:0]     winner;
    int                  rot;
    int                  rnk;
    int                  thr_rank;
    int                  win_rank;

    assign gnt.grant_valid = offer_vld;
    assign gnt.grant_id    = offer_id;

    assign acc      = offer_vld & gnt.grant_ready;
    assign acc_mask = acc ? (NUM_SRC'(1) << offer_id) : '0;

    // Ranks are relative to the rotation base; rank 0 is the highest priority.
    always_comb begin
        rise      = irq & ~irq_q;
        rot       = 0;
`ifdef IRQ_ROTATE_PRIORITY_EN
        rot       = int'(ptr);
`endif
        rnk       = 0;
        thr_rank  = NUM_SRC;
        thr_mask  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            rnk = (i + NUM_SRC - rot) % NUM_SRC;
            if (in_service[i] && (rnk < thr_rank)) begin
                thr_rank = rnk;
                thr_mask = NUM_SRC'(1) << i;
            end
        end
        eoi_clear = eoi ? thr_mask : '0;
        nest_full = ($countones(in_service) >= MAX_NEST);
        win_rank  = NUM_SRC;
        winner    = '0;
        any_elig  = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            rnk = (i + NUM_SRC - rot) % NUM_SRC;
            if (!nest_full && pending[i] && imr[i] && (rnk < thr_rank) && (rnk < win_rank)) begin
                win_rank = rnk;
                winner   = ID_W'(i);
                any_elig = 1'b1;
            end
        end
    end

    // A rise on the source being accepted re-sets its pending bit, so it is never lost.
    always_ff @(posedge clk) begin
        irq_q <= irq;
        if (rst) begin
            state      <= IDLE;
            pending    <= '0;
            in_service <= '0;
            offer_vld  <= 1'b0;
            offer_id   <= '0;
            eoi_err    <= 1'b0;
`ifdef IRQ_ROTATE_PRIORITY_EN
            ptr        <= '0;
`endif
        end else begin
            pending    <= (pending & ~acc_mask) | rise;
            in_service <= (in_service & ~eoi_clear) | acc_mask;
            eoi_err    <= eoi && (in_service == '0);
            case (state)
                IDLE: begin
                    if (any_elig) begin
                        state     <= OFFER;
                        offer_vld <= 1'b1;
                        offer_id  <= winner;
                    end
                end
                OFFER: begin
                    if (gnt.grant_ready) begin
                        state     <= IDLE;
                        offer_vld <= 1'b0;
`ifdef IRQ_ROTATE_PRIORITY_EN
                        ptr       <= ID_W'((int'(offer_id) + 1) % NUM_SRC);
`endif
                    end
                end
                default: begin
                    state     <= IDLE;
                    offer_vld <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_priority_scheduler.sv
// Self-checking bench for irq_priority_scheduler: directed scenarios plus a randomized run against a behavioural model.
module tb_irq_priority_scheduler;

    localparam int N    = 8;
    localparam int IDW  = 3;
    localparam int NEST = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] irq = '0;
    logic [N-1:0] imr = '1;
    logic         eoi = 1'b0;
    logic [N-1:0] pending;
    logic [N-1:0] in_service;
    logic         eoi_err;

    irq_priority_scheduler_if #(.ID_W(IDW)) gif ();

    irq_priority_scheduler #(.NUM_SRC(N), .ID_W(IDW), .MAX_NEST(NEST)) dut (
        .clk        (clk),
        .rst        (rst),
        .irq        (irq),
        .imr        (imr),
        .eoi        (eoi),
        .pending    (pending),
        .in_service (in_service),
        .eoi_err    (eoi_err),
        .gnt        (gif)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [N-1:0] m_pend, m_isr, m_irq_q;
    logic         m_valid, m_err;
    int           m_id, m_ptr;

    function automatic int rk(int i);
`ifdef IRQ_ROTATE_PRIORITY_EN
        return (i - m_ptr + N) % N;
`else
        return i;
`endif
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int thr, best, cnt;
        logic acc;
        logic [N-1:0] np, ni;
        if (rst) begin
            m_pend = '0; m_isr = '0; m_valid = 1'b0; m_id = 0; m_err = 1'b0; m_ptr = 0;
            m_irq_q = irq;
            return;
        end
        cnt = 0;
        thr = N;
        for (int i = 0; i < N; i++)
            if (m_isr[i]) begin
                cnt++;
                if (rk(i) < thr) thr = rk(i);
            end
        best = -1;
        if (cnt < NEST)
            for (int i = 0; i < N; i++)
                if (m_pend[i] && imr[i] && rk(i) < thr && (best < 0 || rk(i) < rk(best))) best = i;
        acc = m_valid && gif.grant_ready;
        np = m_pend;
        if (acc) np[m_id] = 1'b0;
        np = np | (irq & ~m_irq_q);
        ni = m_isr;
        if (eoi && m_isr != 0)
            for (int i = 0; i < N; i++)
                if (m_isr[i] && rk(i) == thr) ni[i] = 1'b0;
        if (acc) ni[m_id] = 1'b1;
        m_err = eoi && (m_isr == 0);
        if (!m_valid) begin
            if (best >= 0) begin
                m_valid = 1'b1;
                m_id = best;
            end
        end else if (gif.grant_ready) begin
            m_valid = 1'b0;
            m_ptr = (m_id + 1) % N;
        end
        m_pend = np;
        m_isr = ni;
        m_irq_q = irq;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check("grant_valid", 32'(gif.grant_valid), 32'(m_valid));
        if (m_valid) check("grant_id", 32'(gif.grant_id), 32'(m_id));
        check("pending", 32'(pending), 32'(m_pend));
        check("in_service", 32'(in_service), 32'(m_isr));
        check("eoi_err", 32'(eoi_err), 32'(m_err));
    endtask

    task automatic pulse(input logic [N-1:0] v);
        irq = v;
        step();
        irq = '0;
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 12 && !gif.grant_valid; i++) step();
        check("wait_valid", 32'(gif.grant_valid), 32'd1);
    endtask

    task automatic accept();
        gif.grant_ready = 1'b1;
        step();
        gif.grant_ready = 1'b0;
    endtask

    task automatic do_eoi();
        eoi = 1'b1;
        step();
        eoi = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (in_service != 0 || pending != 0 || gif.grant_valid); i++) begin
            gif.grant_ready = gif.grant_valid;
            eoi = (in_service != 0) && !gif.grant_valid;
            step();
        end
        gif.grant_ready = 1'b0;
        eoi = 1'b0;
        check("drained", 32'({pending, in_service}), 32'd0);
    endtask

    initial begin
        gif.grant_ready = 1'b0;
        // Reset
        step();
        step();
        rst = 1'b0;
        check("reset_valid", 32'(gif.grant_valid), 32'd0);
        check("reset_pending", 32'(pending), 32'd0);

        // Single request on line 3, two cycles from edge to offer
        pulse(8'h08);
        check("lat_valid_early", 32'(gif.grant_valid), 32'd0);
        step();
        check("lat_valid", 32'(gif.grant_valid), 32'd1);
        check("lat_id", 32'(gif.grant_id), 32'd3);
        accept();
        check("acc_pending", 32'(pending), 32'h00);
        check("acc_isr", 32'(in_service), 32'h08);
        do_eoi();
        check("eoi_isr", 32'(in_service), 32'h00);

        // Simultaneous rises served in priority order
        pulse(8'h15);
        for (int k = 0; k < 3; k++) begin
            wait_valid();
            check("order_id", 32'(gif.grant_id), 32'(2 * k));
            accept();
            do_eoi();
            check("order_isr", 32'(in_service), 32'h00);
        end

        // Masked request stays pending
        imr = 8'hFE;
        pulse(8'h01);
        for (int k = 0; k < 20; k++) step();
        check("mask_valid", 32'(gif.grant_valid), 32'd0);
        check("mask_pending", 32'(pending), 32'h01);
        imr = 8'hFF;
        step();
        check("unmask_id", 32'(gif.grant_id), 32'd0);
        check("unmask_valid", 32'(gif.grant_valid), 32'd1);
        accept();
        do_eoi();

        // Nesting and the nesting limit
        pulse(8'h20);
        wait_valid();
        check("nest_id5", 32'(gif.grant_id), 32'd5);
        accept();
        pulse(8'h40);
        for (int k = 0; k < 5; k++) step();
        check("nest_low_blocked", 32'(gif.grant_valid), 32'd0);
        pulse(8'h02);
        wait_valid();
        check("nest_id1", 32'(gif.grant_id), 32'd1);
        accept();
        check("nest_isr", 32'(in_service), 32'h22);
        pulse(8'h01);
        for (int k = 0; k < 5; k++) step();
        check("nest_full_blocked", 32'(gif.grant_valid), 32'd0);
        do_eoi();
        check("nest_eoi_isr", 32'(in_service), 32'h20);
        wait_valid();
        check("nest_id0", 32'(gif.grant_id), 32'd0);
        accept();
        drain();

        // EOI with nothing in service
        do_eoi();
        check("eoi_err_pulse", 32'(eoi_err), 32'd1);
        step();
        check("eoi_err_clear", 32'(eoi_err), 32'd0);
        check("eoi_err_isr", 32'(in_service), 32'h00);

        // Accept and EOI in the same cycle
        pulse(8'h08);
        wait_valid();
        accept();
        pulse(8'h04);
        wait_valid();
        check("same_id2", 32'(gif.grant_id), 32'd2);
        gif.grant_ready = 1'b1;
        eoi = 1'b1;
        step();
        gif.grant_ready = 1'b0;
        eoi = 1'b0;
        check("same_isr", 32'(in_service), 32'h04);
        drain();

        // Offer held stable under backpressure, then reset mid-offer
        pulse(8'h08);
        wait_valid();
        pulse(8'h01);
        for (int k = 0; k < 4; k++) begin
            step();
            check("hold_id", 32'(gif.grant_id), 32'd3);
        end
        accept();
        check("hold_after_acc", 32'(gif.grant_valid), 32'd0);
        step();
        check("hold_next_valid", 32'(gif.grant_valid), 32'd1);
        check("hold_next_id", 32'(gif.grant_id), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_offer", 32'(gif.grant_valid), 32'd0);
        check("rst_isr", 32'(in_service), 32'h00);

        // Randomized traffic against the model
        for (int k = 0; k < 600; k++) begin
            irq = N'($urandom & $urandom);
            imr = ($urandom_range(0, 9) == 0) ? N'($urandom) : '1;
            gif.grant_ready = 1'($urandom_range(0, 1));
            eoi = ($urandom_range(0, 5) == 0);
            rst = ($urandom_range(0, 249) == 0);
            step();
        end
        rst = 1'b0;
        irq = '0;
        imr = '1;
        eoi = 1'b0;
        gif.grant_ready = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
